// File: rtl/gshare_pattern_table.sv
// Gshare pattern history table: 2-bit counters indexed by PC^GHR,
// predicting in DEC and training from the EX branch resolution.
module gshare_pattern_table #(
  parameter int BPRED_WIDTH = 8,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic [31:0]            i_DEC_PC,
  input  logic [BPRED_WIDTH-1:0] i_Global_History,
  input  logic                   i_Stall,
  input  logic                   i_Flush,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  output logic                   o_Prediction,
  output logic                   o_Mispredict,
  output logic [STAT_WIDTH-1:0]  o_Branch_Count,
  output logic [STAT_WIDTH-1:0]  o_Mispred_Count
);

  localparam int DEPTH = 1 << BPRED_WIDTH;

  logic [1:0]             pht [DEPTH];
  logic                   ex_valid;
  logic [BPRED_WIDTH-1:0] ex_idx;
  logic                   ex_pred;

  logic [BPRED_WIDTH-1:0] dec_idx;
  logic                   resolve;
  logic [1:0]             ex_ctr;
  logic [1:0]             ex_ctr_nxt;
  logic [1:0]             dec_ctr;
  logic                   fwd_hit;
  logic                   unused_pc;

  assign unused_pc = ^{i_DEC_PC[31:BPRED_WIDTH+2], i_DEC_PC[1:0]};

  assign dec_idx = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History;
  assign resolve = i_ALU_Branch_Valid & ex_valid;
  assign ex_ctr  = pht[ex_idx];

  always_comb begin
    ex_ctr_nxt = ex_ctr;
    if (i_ALU_Branch_Outcome) begin
      if (ex_ctr != 2'b11)
        ex_ctr_nxt = ex_ctr + 2'b01;
    end else begin
      if (ex_ctr != 2'b00)
        ex_ctr_nxt = ex_ctr - 2'b01;
    end
  end

  // Same-cycle EX write to the DEC entry is bypassed
  assign fwd_hit = resolve & (ex_idx == dec_idx);

  always_comb begin
    dec_ctr = pht[dec_idx];
    if (fwd_hit)
      dec_ctr = ex_ctr_nxt;
  end

  assign o_Prediction = dec_ctr[1];
  assign o_Mispredict = resolve & (ex_pred ^ i_ALU_Branch_Outcome);

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int i = 0; i < DEPTH; i++)
        pht[i] <= 2'b10;
    end else if (resolve) begin
      pht[ex_idx] <= ex_ctr_nxt;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      ex_valid <= 1'b0;
      ex_idx   <= '0;
      ex_pred  <= 1'b0;
    end else begin
      unique case (1'b1)
        i_Flush: ex_valid <= 1'b0;
        i_Stall: ex_valid <= 1'b0;
        default: begin
          ex_valid <= i_DEC_Is_Branch;
          ex_idx   <= dec_idx;
          ex_pred  <= o_Prediction;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      o_Branch_Count  <= '0;
      o_Mispred_Count <= '0;
    end else if (resolve) begin
      if (~&o_Branch_Count)
        o_Branch_Count <= o_Branch_Count + 1'b1;
      if (o_Mispredict && ~&o_Mispred_Count)
        o_Mispred_Count <= o_Mispred_Count + 1'b1;
    end
  end

endmodule
